// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
//   Shared definitions for the MIPS32 fetch front end:
//     - 6-bit opcode constants for the supported instruction set
//     - 3-bit instruction class codes produced by the fetch predecoder
//     - predecode(): maps an instruction word to its class code
//   Only the optional predecode path (FETCH_PREDECODE_EN) in mips_fetch_queue
//   uses the function. The opcode constants are always available.
// -----------------------------------------------------------------------------
package mips32_pkg;

  // Register-register ALU operations
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;

  // Memory operations
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;

  // Register-immediate ALU operations
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;

  // Conditional branches
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;

  // Stop the machine
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Instruction class codes carried alongside each queued instruction
  typedef enum logic [2:0] {
    TYPE_RR_ALU = 3'd0,
    TYPE_RM_ALU = 3'd1,
    TYPE_LOAD   = 3'd2,
    TYPE_STORE  = 3'd3,
    TYPE_BRANCH = 3'd4,
    TYPE_HALT   = 3'd5
  } instr_type_e;

  localparam int TYPE_W = 3;

  // Classify an instruction from its opcode field. Anything not recognised is
  // treated as HALT so that a corrupted or unsupported word stops the machine
  // rather than executing as something arbitrary.
  function automatic instr_type_e predecode(input logic [31:0] ir);
    instr_type_e t;
    t = TYPE_HALT;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = TYPE_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                    t = TYPE_RM_ALU;
      OP_LW:                                        t = TYPE_LOAD;
      OP_SW:                                        t = TYPE_STORE;
      OP_BNEQZ, OP_BEQZ:                            t = TYPE_BRANCH;
      OP_HLT:                                       t = TYPE_HALT;
      default:                                      t = TYPE_HALT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry circular buffer holding fetched instructions. Read and write
//   pointers wrap naturally because DEPTH is a power of two. An explicit
//   occupancy counter tells full from empty.
//
//   Ports
//     clk, rst_n  clock, asynchronous active-low reset
//     flush       discard every entry (wins over push and pop)
//     push        write wdata at the tail on this edge
//     wdata       entry to write
//     pop         drop the head entry on this edge (caller guarantees !empty)
//     rdata       head entry (unregistered read of the storage array)
//     count       number of occupied entries, 0..DEPTH
//     empty       count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_V = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full;

  // Pointer and occupancy next-state. A flush empties the buffer outright.
  // Otherwise push and pop move their own pointer, and a simultaneous push
  // and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers. Reset abandons every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array. It is not reset because the pointers and count decide
  // what is valid, and the top gates the head with the valid flag.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // A push without a matching pop into a full buffer would overwrite the
  // oldest entry. The fetch rule in the top is meant to make this impossible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push && !pop) begin
      assert (!full);
    end
  end

  always_comb begin
    full  = (count_q == DEPTH_V);
    empty = (count_q == '0);
    count = count_q;
    rdata = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// -----------------------------------------------------------------------------
// mips_fetch_queue
//   Instruction fetch unit with a small decoupling queue. It keeps the program
//   counter and issues one word read per cycle while there is room for the
//   response. Each response is queued together with its next-PC. Taken-branch
//   redirects flush the queue, and halt stops new fetches while the queue
//   drains.
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     imem_req         fetch request this cycle
//     imem_addr        word address of the request (pc[ADDR_W-1:0])
//     imem_rdata       instruction word, valid one cycle after imem_req
//     redirect_valid   taken branch: flush and refetch from redirect_pc
//     redirect_pc      branch target word address
//     halt             stop issuing fetches; queued words still drain
//     out_valid        queue head holds an instruction
//     out_ready        decode accepts the head
//     out_ir           head instruction word (0 when empty)
//     out_npc          head fetch address + 1 (0 when empty)
//     count            occupied queue entries
//     out_type         head instruction class, only when FETCH_PREDECODE_EN
//                      is defined
//
//   Configuration macro: FETCH_PREDECODE_EN
// -----------------------------------------------------------------------------
module mips_fetch_queue
  import mips32_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_npc,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_PREDECODE_EN
  ,
  output logic [2:0]               out_type
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = DEPTH[CW:0];

`ifdef FETCH_PREDECODE_EN
  localparam int EW = 64 + TYPE_W;
`else
  localparam int EW = 64;
`endif

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic          push, pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [EW-1:0] fifo_wdata, fifo_rdata;

  // Request and enqueue decisions.
  // - occupancy is the number of slots that will be committed after this
  //   edge: queued entries, plus the response already on its way, minus the
  //   entry being popped. A new request may issue only when a slot is still
  //   free for its response, so the queue cannot overflow.
  // - imem_req is also gated by rst_n so that no request is visible while
  //   reset is held.
  // - A redirect in the response cycle discards that response, the same way
  //   the flush discards the queued entries.
  always_comb begin
    pop       = out_valid && out_ready;
    occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    imem_req  = rst_n && !halt && !redirect_valid && (occupancy < DEPTH_V);
    push      = inflight_q && !kill_q && !redirect_valid;
  end

  // PC and in-flight tracking. A redirect loads the target. Otherwise every
  // issued request advances the PC, and the 32-bit adder wraps on its own.
  // kill_d marks a request that a same-cycle redirect has made stale. The
  // fetch rule never issues during a redirect, but the flag keeps a stale
  // response out of the queue even if that gating changes.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = imem_req;
    kill_d     = imem_req && redirect_valid;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d = pc_q + 32'd1;
    end
  end

  // State registers. Reset abandons any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  // Entry packing. In the response cycle pc_q already holds the fetch
  // address + 1. It only moves again on the closing edge of that cycle, so
  // it is exactly the next-PC to store with the word.
  always_comb begin
`ifdef FETCH_PREDECODE_EN
    fifo_wdata = {predecode(imem_rdata), pc_q, imem_rdata};
`else
    fifo_wdata = {pc_q, imem_rdata};
`endif
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Head outputs come straight from the queue. They are forced to zero while
  // the queue is empty, so the unreset storage never shows on the outputs.
  always_comb begin
    imem_addr = pc_q[ADDR_W-1:0];
    count     = fifo_count;
    out_valid = !fifo_empty;
    out_ir    = out_valid ? fifo_rdata[31:0]  : 32'd0;
    out_npc   = out_valid ? fifo_rdata[63:32] : 32'd0;
`ifdef FETCH_PREDECODE_EN
    out_type  = out_valid ? fifo_rdata[66:64] : 3'd0;
`endif
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_queue
//   Directed bench for mips_fetch_queue. It has a one-cycle-latency
//   instruction memory model. The sequences are streaming, backpressure,
//   redirect, PC wrap, halt and asynchronous reset. The predecode sequence
//   runs only when FETCH_PREDECODE_EN is defined.
// -----------------------------------------------------------------------------
module tb_mips_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
  logic [2:0]  count;
`ifdef FETCH_PREDECODE_EN
  logic [2:0]  out_type;
`endif

  logic [31:0] mem [1024];
  int          checks = 0;
  int          errors = 0;

  mips_fetch_queue #(
    .DEPTH  (4),
    .ADDR_W (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_npc        (out_npc),
    .count          (count)
`ifdef FETCH_PREDECODE_EN
    ,
    .out_type       (out_type)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the word is returned the cycle after the request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  // Absolute time limit so a broken design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit exceeded");
  end

  // Advance to 1 ns after the next rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset across two edges, then release it just after an edge. On
  // return the bench is in cycle 0, the first cycle with rst_n high.
  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;
    imem_rdata     = 32'd0;

    // ---------------- reset state ----------------
    #2;
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_imem_req",  32'(imem_req),  32'd0);
    checkOutput("rst_out_ir",    out_ir,         32'd0);
    checkOutput("rst_out_npc",   out_npc,        32'd0);

    // ---------------- streaming ----------------
    doReset();
    checkOutput("stream_first_req",  32'(imem_req),  32'd1);
    checkOutput("stream_first_addr", 32'(imem_addr), 32'd0);
    applyStimulus();
    checkOutput("stream_valid_e1", 32'(out_valid), 32'd0);
    applyStimulus();
    checkOutput("stream_valid_e2", 32'(out_valid), 32'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("stream_ir_%0d", k),  out_ir,  mem[k]);
      checkOutput($sformatf("stream_npc_%0d", k), out_npc, 32'(k + 1));
      applyStimulus();
    end

    // ---------------- backpressure ----------------
    // The head is now mem[8]. Hold off decode for 10 cycles.
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) applyStimulus();
    checkOutput("bp_count_full", 32'(count),     32'd4);
    checkOutput("bp_req_off",    32'(imem_req),  32'd0);
    checkOutput("bp_valid",      32'(out_valid), 32'd1);
    checkOutput("bp_ir_held",    out_ir,         mem[8]);
    checkOutput("bp_npc_held",   out_npc,        32'd9);
    out_ready = 1'b1;
    #1;
    for (int k = 8; k < 16; k++) begin
      checkOutput($sformatf("bp_ir_%0d", k), out_ir, mem[k]);
      applyStimulus();
    end

    // ---------------- redirect ----------------
    // Address 0 is requested in cycle 0, and its response arrives in cycle 1
    // together with the redirect, so the word must be dropped.
    doReset();
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    #1;
    checkOutput("redir_req_blocked", 32'(imem_req), 32'd0);
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("redir_valid_after", 32'(out_valid), 32'd0);
    checkOutput("redir_count_after", 32'(count),     32'd0);
    checkOutput("redir_req",         32'(imem_req),  32'd1);
    checkOutput("redir_addr",        32'(imem_addr), 32'h20);
    applyStimulus();
    checkOutput("redir_valid_wait", 32'(out_valid), 32'd0);
    applyStimulus();
    checkOutput("redir_ir",   out_ir,  mem[32'h20]);
    checkOutput("redir_npc",  out_npc, 32'h21);
    applyStimulus();
    checkOutput("redir_ir_next", out_ir, mem[32'h21]);

    // ---------------- PC wrap ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("wrap_addr", 32'(imem_addr), 32'h3FF);
    applyStimulus();
    checkOutput("wrap_addr_next", 32'(imem_addr), 32'h000);
    applyStimulus();
    checkOutput("wrap_ir",  out_ir,  mem[1023]);
    checkOutput("wrap_npc", out_npc, 32'd0);
    applyStimulus();
    checkOutput("wrap_ir_next",  out_ir,  mem[0]);
    checkOutput("wrap_npc_next", out_npc, 32'd1);

    // ---------------- halt ----------------
    // pc reaches 5 in cycle 5, when addresses 0..4 have been requested
    doReset();
    for (int c = 0; c < 5; c++) applyStimulus();
    checkOutput("halt_pc5_addr", 32'(imem_addr), 32'd5);
    halt = 1'b1;
    #1;
    checkOutput("halt_req_stop", 32'(imem_req), 32'd0);
    checkOutput("halt_ir3",      out_ir,        mem[3]);
    applyStimulus();
    checkOutput("halt_ir4",   out_ir,        mem[4]);
    checkOutput("halt_req_1", 32'(imem_req), 32'd0);
    applyStimulus();
    checkOutput("halt_count0", 32'(count),     32'd0);
    checkOutput("halt_valid0", 32'(out_valid), 32'd0);
    applyStimulus();
    checkOutput("halt_req_2",  32'(imem_req),  32'd0);
    checkOutput("halt_addr5",  32'(imem_addr), 32'd5);
    halt = 1'b0;
    #1;
    checkOutput("halt_resume_req",  32'(imem_req),  32'd1);
    checkOutput("halt_resume_addr", 32'(imem_addr), 32'd5);
    applyStimulus();
    applyStimulus();
    checkOutput("halt_resume_ir", out_ir, mem[5]);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    doReset();
    for (int c = 0; c < 4; c++) applyStimulus();
    checkOutput("mrst_count3", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_count0", 32'(count),     32'd0);
    checkOutput("mrst_valid0", 32'(out_valid), 32'd0);
    checkOutput("mrst_req0",   32'(imem_req),  32'd0);
    checkOutput("mrst_ir0",    out_ir,         32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("mrst_refetch_req",  32'(imem_req),  32'd1);
    checkOutput("mrst_refetch_addr", 32'(imem_addr), 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("mrst_refetch_ir", out_ir, mem[0]);

`ifdef FETCH_PREDECODE_EN
    // ---------------- predecode ----------------
    begin
      logic [5:0] ops [7];
      logic [2:0] types [7];
      ops   = '{6'b000000, 6'b001010, 6'b001000, 6'b001001, 6'b001110, 6'b111111, 6'b010101};
      types = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
      for (int i = 0; i < 7; i++) mem[i] = {ops[i], 26'(i)};
      doReset();
      applyStimulus();
      applyStimulus();
      for (int i = 0; i < 7; i++) begin
        checkOutput($sformatf("pdec_type_%0d", i), 32'(out_type), 32'(types[i]));
        applyStimulus();
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
